// File: rtl/moving_average_sequencer.sv
// Flow-control wrapper and issue scheduler for a handshake-less moving-average core.
// Optional statistics counters (drop_cnt, stall_cnt) are enabled with `define MA_SEQ_STATS_EN.
module moving_average_sequencer #(
    parameter int DATA_W    = 8,
    parameter int WINDOW    = 4,
    parameter int CORE_LAT  = 1,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              core_en,
    output logic [DATA_W-1:0] core_x,
    input  logic [DATA_W-1:0] core_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef MA_SEQ_STATS_EN
    ,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
    localparam int CRED_W = OUT_CW + 1;
    localparam int WARM_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WINDOW - 1);

    typedef enum logic {WARM, RUN} state_t;
    localparam state_t INIT_STATE = (WINDOW > 1) ? WARM : RUN;

    state_t state, state_next;

    logic [DATA_W-1:0]   in_mem [IN_DEPTH];
    logic [IN_AW-1:0]    in_rd, in_wr;
    logic [IN_CW-1:0]    in_cnt;
    logic [DATA_W-1:0]   out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]   out_rd, out_wr;
    logic [OUT_CW-1:0]   out_cnt;
    logic [OUT_CW-1:0]   inflight;
    logic [WARM_W-1:0]   warm_cnt;
    logic                keep_q;
    logic                draining;
    logic [CORE_LAT-1:0] tag_v, tag_k;

    logic in_empty, credit_ok, issue, keep;
    logic in_push, out_push, out_pop, ret_v, ret_k;

    function automatic logic [OUT_AW-1:0] out_inc(input logic [OUT_AW-1:0] p);
        return (p == OUT_AW'(OUT_DEPTH - 1)) ? '0 : p + OUT_AW'(1);
    endfunction

    // Issue and credit depend only on registered state; clear merely vetoes.
    assign in_empty  = (in_cnt == '0);
    assign in_ready  = (in_cnt != IN_CW'(IN_DEPTH));
    assign credit_ok = (CRED_W'(inflight) + CRED_W'(out_cnt)) < CRED_W'(OUT_DEPTH);
    assign issue     = !clear && !draining && !in_empty && credit_ok;
    assign keep      = (warm_cnt == WARM_MAX);
    assign ret_v     = tag_v[CORE_LAT-1];
    assign ret_k     = tag_k[CORE_LAT-1];
    assign in_push   = in_valid && in_ready && !clear;
    assign out_push  = ret_v && ret_k && !clear;
    assign out_pop   = out_valid && out_ready && !clear;
    assign out_valid = (out_cnt != '0);
    assign out_data  = out_mem[out_rd];

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state <= INIT_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = INIT_STATE;
        end else begin
            case (state)
                WARM:    if (issue && (warm_cnt + WARM_W'(1)) == WARM_MAX) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = INIT_STATE;
            endcase
        end
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            in_rd    <= '0;
            in_wr    <= '0;
            in_cnt   <= '0;
            out_rd   <= '0;
            out_wr   <= '0;
            out_cnt  <= '0;
            inflight <= '0;
            warm_cnt <= '0;
            draining <= 1'b0;
            keep_q   <= 1'b0;
            core_en  <= 1'b0;
            core_x   <= '0;
            tag_v    <= '0;
            tag_k    <= '0;
            for (int unsigned i = 0; i < IN_DEPTH; i++) in_mem[i] <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
        end else begin
            core_en <= issue;
            keep_q  <= issue && keep;
            if (issue) core_x <= in_mem[in_rd];

            // Tags keep flowing through clear so in-flight credits still return, but lose keep.
            tag_v    <= (tag_v << 1) | CORE_LAT'(core_en);
            tag_k    <= clear ? '0 : ((tag_k << 1) | CORE_LAT'(keep_q));
            inflight <= inflight + OUT_CW'(issue) - OUT_CW'(ret_v);

            if (clear) begin
                draining <= 1'b1;
            end else if (inflight == '0) begin
                draining <= 1'b0;
            end

            if (clear) begin
                in_rd    <= '0;
                in_wr    <= '0;
                in_cnt   <= '0;
                out_rd   <= '0;
                out_wr   <= '0;
                out_cnt  <= '0;
                warm_cnt <= '0;
            end else begin
                if (in_push) begin
                    in_mem[in_wr] <= in_data;
                    in_wr         <= in_wr + IN_AW'(1);
                end
                if (issue) in_rd <= in_rd + IN_AW'(1);
                in_cnt <= in_cnt + IN_CW'(in_push) - IN_CW'(issue);

                if (out_push) begin
                    out_mem[out_wr] <= core_y;
                    out_wr          <= out_inc(out_wr);
                end
                if (out_pop) out_rd <= out_inc(out_rd);
                out_cnt <= out_cnt + OUT_CW'(out_push) - OUT_CW'(out_pop);

                if (issue && state == WARM) warm_cnt <= warm_cnt + WARM_W'(1);
            end
        end
    end

`ifdef MA_SEQ_STATS_EN
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            drop_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (ret_v && (!ret_k || clear) && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            if (!in_empty && !credit_ok && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_moving_average_sequencer.sv
// Scoreboard bench for moving_average_sequencer with a behavioural core model.
module tb_moving_average_sequencer;

    localparam int DATA_W    = 8;
    localparam int WINDOW    = 4;
    localparam int CORE_LAT  = 1;
    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, core_en, out_valid;
    logic [7:0]  core_x, core_y, out_data;
`ifdef MA_SEQ_STATS_EN
    logic [15:0] drop_cnt, stall_cnt;
`endif

    moving_average_sequencer #(
        .DATA_W(DATA_W), .WINDOW(WINDOW), .CORE_LAT(CORE_LAT),
        .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .system1000(clk), .system1000_rstn(rstn), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_en(core_en), .core_x(core_x), .core_y(core_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MA_SEQ_STATS_EN
        , .drop_cnt(drop_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int core_mode = 0;
    int accepted_since = 0;
    int accepted_total = 0;
    int core_en_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];

    function automatic logic [7:0] core_f(input logic [7:0] x);
        logic [15:0] p;
        p = {8'b0, x} * 16'd10;
        return (core_mode == 0) ? p[7:0] : x;
    endfunction

    // Core model: result appears CORE_LAT cycles after the edge that sees core_en.
    logic [7:0] core_pipe [CORE_LAT];
    always @(posedge clk) begin
        if (core_en) core_pipe[0] <= core_f(core_x);
        for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_y = core_pipe[CORE_LAT-1];

    // Reference: after reset/clear the first WINDOW-1 accepted samples are masked;
    // clear or reset discards everything not yet delivered.
    always @(negedge clk) begin
        if (!rstn || clear) begin
            exp_q.delete();
            accepted_since = 0;
        end else if (in_valid && in_ready) begin
            if (accepted_since >= WINDOW - 1) exp_q.push_back(core_f(in_data));
            accepted_since++;
            accepted_total++;
        end
        if (rstn && core_en) core_en_cnt++;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rstn && !clear && out_valid && out_ready) begin
            tests++;
            seen_q.push_back(out_data);
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got 0x%02h, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL out_data: got 0x%02h, expected 0x%02h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(8);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_en, base_acc, base_seen, n;
        bit found, bp_done;
        logic [7:0] x4;

        // Reset held three edges with a sample offered
        in_valid = 1'b1;
        in_data  = 8'd55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_core_en", core_en, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_out_data", out_data, 0);
            check("rst_core_x", core_x, 0);
        end
        in_valid = 1'b0;
        rstn = 1'b1;
        idle(10);
        check("rst_no_issue", core_en_cnt, 0);
        check("rst_fifo_empty", in_ready, 1);

        // Streaming 1..8 with core returning 10*x
        core_mode = 0;
        out_ready = 1'b1;
        base_en   = core_en_cnt;
        base_seen = seen_q.size();
        for (int v = 1; v <= 8; v++) begin
            send(8'(v));
            idle(6);
        end
        wait_drain("stream_drain");
        idle(10);
        check("stream_issues", core_en_cnt - base_en, 8);
        check("stream_results", seen_q.size() - base_seen, 5);
        check("stream_first", seen_q[base_seen], 40);
        check("stream_last", seen_q[base_seen + 4], 80);
`ifdef MA_SEQ_STATS_EN
        check("stats_drop", drop_cnt, 3);
        check("stats_stall", stall_cnt, 0);
`endif

        // Backpressure: 10 samples, consumer stalled
        out_ready = 1'b0;
        base_en   = core_en_cnt;
        base_acc  = accepted_total;
        base_seen = seen_q.size();
        bp_done   = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(8'($urandom));
                bp_done = 1'b1;
            end
        join_none
        idle(40);
        check("bp_issues", core_en_cnt - base_en, 2);
        check("bp_accepted", accepted_total - base_acc, 6);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        n = 0;
        while (!bp_done && n < 2000) begin
            idle(1);
            n++;
        end
        check("bp_sender_done", bp_done, 1);
        wait_drain("bp_drain");
        check("bp_results", seen_q.size() - base_seen, 10);

        // Signed extremes with identity core
        core_mode = 1;
        base_seen = seen_q.size();
        send(8'h80);
        send(8'h7F);
        send(8'hFF);
        send(8'h00);
        for (int i = 0; i < 4; i++) send(8'($urandom));
        wait_drain("ext_drain");
        check("ext_count", seen_q.size() - base_seen, 8);
        check("ext_m128", seen_q[base_seen], 32'h80);
        check("ext_p127", seen_q[base_seen + 1], 32'h7F);
        check("ext_m1", seen_q[base_seen + 2], 32'hFF);
        check("ext_zero", seen_q[base_seen + 3], 32'h00);

        // Clear on the edge that completes a core_en issue
        bp_done = 1'b0;
        fork
            begin
                send(8'd11);
                send(8'd22);
                send(8'd33);
                bp_done = 1'b1;
            end
        join_none
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (core_en) begin
                found = 1'b1;
                break;
            end
        end
        check("clr_sees_issue", found, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        n = 0;
        while (!bp_done && n < 1000) begin
            idle(1);
            n++;
        end
        idle(10);
        base_seen = seen_q.size();
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom));
            idle(8);
        end
        check("clr_warmup_masked", seen_q.size() - base_seen, 0);
        x4 = 8'($urandom);
        send(x4);
        wait_drain("clr_drain");
        check("clr_first_new", seen_q.size() - base_seen, 1);
        check("clr_first_value", seen_q[seen_q.size() - 1], x4);

        // Randomised traffic with occasional clears
        core_mode = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("rand_drain");

        // Reset mid-operation discards everything
        out_ready = 1'b0;
        base_seen = seen_q.size();
        for (int i = 0; i < 6; i++) send(8'($urandom));
        idle(4);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_core_en", core_en, 0);
        rstn = 1'b1;
        out_ready = 1'b1;
        idle(20);
        check("mid_rst_discard", seen_q.size() - base_seen, 0);
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
